// File: rtl/data_mem_pkg.sv
// Shared definitions for the data memory arbiter: default widths, FSM states
// and requester ids.
package data_mem_pkg;

    localparam int DEF_ADDR_W = 6;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/arb_rr_pick.sv
// Two-way round-robin picker: on a tie the requester not granted last wins.
module arb_rr_pick
    import data_mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant,
    output logic       valid
);

    always_comb begin
        valid = |req;
        if (&req) begin
            grant = ~last_grant;
        end else begin
            grant = req[1] ? REQ_D : REQ_I;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Arbitrates the shared block data memory between the I-cache (read only)
// and the D-cache (read / write-back), one access at a time.
module data_mem_arbiter
    import data_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [DATA_W-1:0] i_readdata,
    output logic              i_busywait,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_writedata,
    output logic [DATA_W-1:0] d_readdata,
    output logic              d_busywait,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_busywait
);

    arb_state_t state;
    logic       winner;
    logic       live;
    logic       last_grant;
    logic       pick_grant;
    logic       pick_valid;
    logic       d_req;
    logic       win_req;

    assign d_req   = d_read | d_write;
    assign win_req = (winner == REQ_D) ? d_req : i_read;

    arb_rr_pick u_pick (
        .req        ({d_req, i_read}),
        .last_grant (last_grant),
        .grant      (pick_grant),
        .valid      (pick_valid)
    );

    // live drops if the winner abandons its request, so a re-raised request
    // is not released by the DONE of the abandoned access.
    assign i_busywait = i_read & ~(state == DONE && winner == REQ_I && live);
    assign d_busywait = d_req  & ~(state == DONE && winner == REQ_D && live);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            winner        <= REQ_I;
            live          <= 1'b0;
            last_grant    <= REQ_D;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
            i_readdata    <= '0;
            d_readdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        winner <= pick_grant;
                        live   <= 1'b1;
                        state  <= ISSUE;
                        // Strobes are registered here so they are visible during ISSUE.
                        if (pick_grant == REQ_D) begin
                            mem_address   <= d_address;
                            mem_writedata <= d_writedata;
                            mem_write     <= d_write;
                            mem_read      <= ~d_write;
                        end else begin
                            mem_address <= i_address;
                            mem_write   <= 1'b0;
                            mem_read    <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (!win_req) live <= 1'b0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (!win_req) live <= 1'b0;
                    if (!mem_busywait) begin
                        if (mem_read && live && win_req) begin
                            if (winner == REQ_D) d_readdata <= mem_readdata;
                            else                 i_readdata <= mem_readdata;
                        end
                        mem_read   <= 1'b0;
                        mem_write  <= 1'b0;
                        last_grant <= winner;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a fixed-latency block memory model.
module tb_data_mem_arbiter;
    import data_mem_pkg::*;

    localparam int AW  = 6;
    localparam int DW  = 32;
    localparam int LAT = 5;
    localparam int S_IBW = 0, S_DBW = 1, S_MRD = 2, S_MWR = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          i_read = 1'b0, d_read = 1'b0, d_write = 1'b0;
    logic [AW-1:0] i_address = '0, d_address = '0;
    logic [DW-1:0] d_writedata = '0;
    logic [DW-1:0] i_readdata, d_readdata, mem_writedata, mem_readdata;
    logic          i_busywait, d_busywait, mem_read, mem_write, mem_busywait;
    logic [AW-1:0] mem_address;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    data_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock         (clock),
        .reset         (reset),
        .i_read        (i_read),
        .i_address     (i_address),
        .i_readdata    (i_readdata),
        .i_busywait    (i_busywait),
        .d_read        (d_read),
        .d_write       (d_write),
        .d_address     (d_address),
        .d_writedata   (d_writedata),
        .d_readdata    (d_readdata),
        .d_busywait    (d_busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
    );

    // Memory: busy for LAT edges after a strobe rises, then completes.
    logic [DW-1:0] mem [0:63];
    int mcnt = 0;
    always @(posedge clock) begin
        if (mem_read || mem_write) mcnt <= mcnt + 1;
        else                       mcnt <= 0;
        if (mem_write && !mem_busywait) mem[mem_address] = mem_writedata;
    end
    assign mem_busywait = (mem_read || mem_write) && (mcnt < LAT);
    assign mem_readdata = mem[mem_address];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            S_IBW:   return i_busywait;
            S_DBW:   return d_busywait;
            S_MRD:   return mem_read;
            default: return mem_write;
        endcase
    endfunction

    // Counts edges until the selected signal reaches level (bounded).
    task automatic wait_for(input int sel, input logic level, output int n);
        n = 0;
        while (sig(sel) !== level && n < 64) begin
            @(posedge clock); #1;
            n++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    always @(negedge clock) check_eq("strobe_excl", 32'(mem_read & mem_write), 32'd0);

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int a = 0; a < 64; a++) mem[a] = '0;
        mem[6'h15] = 32'hDEADBEEF;
        mem[6'h10] = 32'hAAAA1111;
        mem[6'h20] = 32'hBBBB2222;
        mem[6'h08] = 32'h11111111;
        mem[6'h30] = 32'h30303030;

        do_reset();
        check_eq("rst_mem_read", 32'(mem_read), 32'd0);
        check_eq("rst_mem_write", 32'(mem_write), 32'd0);
        check_eq("rst_mem_address", 32'(mem_address), 32'd0);
        check_eq("rst_i_readdata", i_readdata, 32'd0);
        check_eq("rst_d_readdata", d_readdata, 32'd0);
        check_eq("rst_busywaits", 32'({i_busywait, d_busywait}), 32'd0);

        // Uncontended I read
        i_address = 6'h15; i_read = 1'b1;
        #1 check_eq("t1_busy_req", 32'(i_busywait), 32'd1);
        @(posedge clock); #1;
        check_eq("t1_mem_read", 32'(mem_read), 32'd1);
        check_eq("t1_mem_write", 32'(mem_write), 32'd0);
        check_eq("t1_mem_address", 32'(mem_address), 32'h15);
        wait_for(S_IBW, 1'b0, n);
        check_eq("t1_latency", 32'(n + 1), 32'(LAT + 2));
        check_eq("t1_i_readdata", i_readdata, 32'hDEADBEEF);
        check_eq("t1_strobe_clear", 32'(mem_read), 32'd0);
        @(posedge clock); #1;
        check_eq("t1_busy_one_cycle", 32'(i_busywait), 32'd1);
        i_read = 1'b0;

        // D write-back
        d_address = 6'h2A; d_writedata = 32'h01234567; d_write = 1'b1;
        @(posedge clock); #1;
        check_eq("t2_mem_write", 32'(mem_write), 32'd1);
        check_eq("t2_mem_read", 32'(mem_read), 32'd0);
        check_eq("t2_mem_address", 32'(mem_address), 32'h2A);
        check_eq("t2_mem_writedata", mem_writedata, 32'h01234567);
        check_eq("t2_i_busywait", 32'(i_busywait), 32'd0);
        wait_for(S_DBW, 1'b0, n);
        check_eq("t2_latency", 32'(n), 32'(LAT + 1));
        check_eq("t2_mem_stored", mem[6'h2A], 32'h01234567);
        check_eq("t2_d_readdata", d_readdata, 32'd0);
        @(posedge clock); #1;
        d_write = 1'b0;

        // Continuous contention after reset: I, D, I, D, I, D
        do_reset();
        i_address = 6'h10; d_address = 6'h20; i_read = 1'b1; d_read = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wait_for(S_MRD, 1'b1, n);
            check_eq("t3_gap", 32'(n), (k == 0) ? 32'd1 : 32'd2);
            check_eq("t3_order", 32'(mem_address), (k % 2 == 0) ? 32'h10 : 32'h20);
            wait_for(S_MRD, 1'b0, n);
            check_eq("t3_access", 32'(n), 32'(LAT + 1));
            if (k % 2 == 0) begin
                check_eq("t3_i_data", i_readdata, 32'hAAAA1111);
                check_eq("t3_bw_win_lose", 32'({i_busywait, d_busywait}), 32'b01);
            end else begin
                check_eq("t3_d_data", d_readdata, 32'hBBBB2222);
                check_eq("t3_bw_win_lose", 32'({i_busywait, d_busywait}), 32'b10);
            end
        end
        i_read = 1'b0; d_read = 1'b0;
        @(posedge clock); #1;

        // d_read and d_write together: write-back only
        d_address = 6'h08; d_writedata = 32'h55AA55AA; d_read = 1'b1; d_write = 1'b1;
        wait_for(S_MWR, 1'b1, n);
        check_eq("t4_issue", 32'(n), 32'd1);
        check_eq("t4_no_read", 32'(mem_read), 32'd0);
        wait_for(S_DBW, 1'b0, n);
        check_eq("t4_latency", 32'(n), 32'(LAT + 1));
        check_eq("t4_d_readdata_held", d_readdata, 32'hBBBB2222);
        check_eq("t4_mem_stored", mem[6'h08], 32'h55AA55AA);
        @(posedge clock); #1;
        d_read = 1'b0; d_write = 1'b0;

        // Reset during WAIT, then re-request
        i_address = 6'h15; i_read = 1'b1;
        @(posedge clock); #1;
        repeat (2) @(posedge clock);
        #1 check_eq("t5_in_wait", 32'(mem_read), 32'd1);
        reset = 1'b0;
        #1;
        check_eq("t5_async_strobe", 32'({mem_read, mem_write}), 32'd0);
        check_eq("t5_i_readdata_rst", i_readdata, 32'd0);
        check_eq("t5_busy_held", 32'(i_busywait), 32'd1);
        @(posedge clock); #1;
        @(posedge clock); #1;
        check_eq("t5_held_in_reset", 32'(mem_read), 32'd0);
        reset = 1'b1;
        wait_for(S_MRD, 1'b1, n);
        check_eq("t5_reissue", 32'(n), 32'd1);
        wait_for(S_IBW, 1'b0, n);
        check_eq("t5_latency", 32'(n), 32'(LAT + 1));
        check_eq("t5_i_readdata", i_readdata, 32'hDEADBEEF);
        @(posedge clock); #1;
        i_read = 1'b0;

        // I drops mid-WAIT while D waits
        mem[6'h15] = 32'hCAFEF00D;
        i_address = 6'h15; i_read = 1'b1;
        @(posedge clock); #1;
        check_eq("t6_i_issue", 32'(mem_address), 32'h15);
        d_address = 6'h30; d_read = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        i_read = 1'b0;
        wait_for(S_MRD, 1'b0, n);
        check_eq("t6_access_completes", 32'(n), 32'(LAT - 1));
        check_eq("t6_i_readdata_held", i_readdata, 32'hDEADBEEF);
        check_eq("t6_i_busywait", 32'(i_busywait), 32'd0);
        wait_for(S_MRD, 1'b1, n);
        check_eq("t6_d_gap", 32'(n), 32'd2);
        check_eq("t6_d_address", 32'(mem_address), 32'h30);
        wait_for(S_DBW, 1'b0, n);
        check_eq("t6_d_latency", 32'(n), 32'(LAT + 1));
        check_eq("t6_d_readdata", d_readdata, 32'h30303030);
        @(posedge clock); #1;
        d_read = 1'b0;
        @(posedge clock); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
